// File: rtl/c880_pkg.sv
// Shared definitions for the c880 vector feeder: FSM state encoding and
// default geometry of the beat stream, core operand and core result.
package c880_pkg;

    localparam int C880_BEAT_W        = 8;
    localparam int C880_IN_W          = 60;
    localparam int C880_OUT_W         = 26;
    localparam int C880_SETTLE_CYCLES = 4;

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        DRAIN  = 2'd1,
        SETTLE = 2'd2,
        OUT    = 2'd3
    } c880_state_t;

endpackage

// File: rtl/c880_vector_feeder.sv
// Assembles inbound beats into an operand vector for a combinational core,
// holds it while the core settles, then offers the captured result downstream.
module c880_vector_feeder
    import c880_pkg::*;
#(
    parameter int BEAT_W        = C880_BEAT_W,
    parameter int IN_W          = C880_IN_W,
    parameter int OUT_W         = C880_OUT_W,
    parameter int SETTLE_CYCLES = C880_SETTLE_CYCLES
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [BEAT_W-1:0] s_data,
    input  logic              s_last,
    output logic [IN_W-1:0]   core_in,
    input  logic [OUT_W-1:0]  core_out,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [OUT_W-1:0]  m_data,
    output logic              err
);

    localparam int NBEATS = (IN_W + BEAT_W - 1) / BEAT_W;
    localparam int BCNT_W = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam logic [BCNT_W-1:0] LAST_BEAT = BCNT_W'(NBEATS - 1);

    c880_state_t       state;
    logic [BCNT_W-1:0] beat_cnt;
    logic [7:0]        settle_cnt;
    logic              accept;
    logic [IN_W-1:0]   beat_mask;
    logic [IN_W-1:0]   beat_bits;
    logic [IN_W-1:0]   core_in_nxt;

    assign s_ready = (state == LOAD) || (state == DRAIN);
    assign accept  = s_valid && s_ready;

    // The final beat overhangs the vector; truncation to IN_W drops its upper bits.
    always_comb begin
        beat_mask   = IN_W'({BEAT_W{1'b1}}) << (int'(beat_cnt) * BEAT_W);
        beat_bits   = IN_W'(s_data) << (int'(beat_cnt) * BEAT_W);
        core_in_nxt = (core_in & ~beat_mask) | (beat_bits & beat_mask);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= LOAD;
            beat_cnt   <= '0;
            settle_cnt <= '0;
            core_in    <= '0;
            m_data     <= '0;
            m_valid    <= 1'b0;
            err        <= 1'b0;
        end else begin
            err <= 1'b0;
            case (state)
                LOAD: begin
                    if (accept) begin
                        core_in <= core_in_nxt;
                        if (beat_cnt == LAST_BEAT) begin
                            beat_cnt <= '0;
                            if (s_last) begin
                                state      <= SETTLE;
                                settle_cnt <= 8'(SETTLE_CYCLES);
                            end else begin
                                err   <= 1'b1;
                                state <= DRAIN;
                            end
                        end else if (s_last) begin
                            err      <= 1'b1;
                            beat_cnt <= '0;
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (accept && s_last) begin
                        state <= LOAD;
                    end
                end
                SETTLE: begin
                    settle_cnt <= settle_cnt - 1'b1;
                    if (settle_cnt == 8'd1) begin
                        m_data  <= core_out;
                        m_valid <= 1'b1;
                        state   <= OUT;
                    end
                end
                OUT: begin
                    if (m_ready) begin
                        m_valid <= 1'b0;
                        state   <= LOAD;
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_c880_vector_feeder.sv
// Bench for c880_vector_feeder: two instances (slow and fast settle) share one
// beat stream and are checked every cycle against a frame-level reference model.
module tb_c880_vector_feeder;
    import c880_pkg::*;

    localparam int S0 = 4;
    localparam int S1 = 1;

    logic        clk = 1'b0;
    logic        rst_n, s_valid, s_last, m_ready;
    logic [7:0]  s_data;
    logic        s_ready_a [2];
    logic        m_valid_a [2];
    logic        err_a     [2];
    logic [59:0] core_in_a [2];
    logic [25:0] core_out_a[2];
    logic [25:0] m_data_a  [2];

    always #5 clk = ~clk;

    function automatic logic [25:0] alu(input logic [59:0] v);
        return 26'(v[29:0] + v[59:30]) ^ v[59:34];
    endfunction

    assign core_out_a[0] = alu(core_in_a[0]);
    assign core_out_a[1] = alu(core_in_a[1]);

    c880_vector_feeder #(.BEAT_W(8), .IN_W(60), .OUT_W(26), .SETTLE_CYCLES(S0)) u0 (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready_a[0]),
        .s_data(s_data), .s_last(s_last), .core_in(core_in_a[0]),
        .core_out(core_out_a[0]), .m_valid(m_valid_a[0]), .m_ready(m_ready),
        .m_data(m_data_a[0]), .err(err_a[0])
    );

    c880_vector_feeder #(.BEAT_W(8), .IN_W(60), .OUT_W(26), .SETTLE_CYCLES(S1)) u1 (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready_a[1]),
        .s_data(s_data), .s_last(s_last), .core_in(core_in_a[1]),
        .core_out(core_out_a[1]), .m_valid(m_valid_a[1]), .m_ready(m_ready),
        .m_data(m_data_a[1]), .err(err_a[1])
    );

    int     nchk = 0;
    int     nfail = 0;
    longint cyc = 0;
    bit     armed = 0;
    bit     rand_mr = 0;
    int     errcnt[2] = '{0, 0};
    int     mvcnt [2] = '{0, 0};

    // Reference model: frame-level view of each instance.
    int          nb     [2];
    bit          drain_m[2];
    bit          busy_m [2];
    longint      res_cyc[2];
    logic [59:0] vec_m  [2];
    logic [25:0] md_m   [2];
    bit          err_m  [2];
    int          settle_of[2] = '{S0, S1};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    initial begin
        bit exp_mv;
        bit e;
        forever begin
            @(negedge clk);
            if (armed) begin
                for (int i = 0; i < 2; i++) begin
                    exp_mv = busy_m[i] && (cyc >= res_cyc[i]);
                    chk($sformatf("s_ready%0d", i), 64'(s_ready_a[i]), 64'(!busy_m[i]));
                    chk($sformatf("m_valid%0d", i), 64'(m_valid_a[i]), 64'(exp_mv));
                    chk($sformatf("err%0d", i), 64'(err_a[i]), 64'(err_m[i]));
                    chk($sformatf("core_in%0d", i), 64'(core_in_a[i]), 64'(vec_m[i]));
                    chk($sformatf("m_data%0d", i), 64'(m_data_a[i]), 64'(md_m[i]));
                    if (err_a[i] === 1'b1) errcnt[i]++;
                    if (m_valid_a[i] === 1'b1) mvcnt[i]++;
                end
            end
            for (int i = 0; i < 2; i++) begin
                if (!rst_n) begin
                    nb[i] = 0; drain_m[i] = 0; busy_m[i] = 0; res_cyc[i] = 0;
                    vec_m[i] = '0; md_m[i] = '0; err_m[i] = 0;
                end else begin
                    e = 0;
                    if (busy_m[i]) begin
                        if (cyc >= res_cyc[i] && m_ready) busy_m[i] = 0;
                        else if (cyc + 1 == res_cyc[i]) md_m[i] = alu(vec_m[i]);
                    end else if (s_valid) begin
                        if (drain_m[i]) begin
                            if (s_last) drain_m[i] = 0;
                        end else if (nb[i] == 7) begin
                            vec_m[i][59:56] = s_data[3:0];
                            nb[i] = 0;
                            if (s_last) begin
                                busy_m[i]  = 1;
                                res_cyc[i] = cyc + settle_of[i] + 1;
                            end else begin
                                e = 1;
                                drain_m[i] = 1;
                            end
                        end else begin
                            vec_m[i][8*nb[i] +: 8] = s_data;
                            if (s_last) begin
                                e = 1;
                                nb[i] = 0;
                            end else begin
                                nb[i]++;
                            end
                        end
                    end
                    err_m[i] = e;
                end
            end
            if (!rst_n) armed = 1;
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            if (rand_mr) m_ready = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic send(input int inst, input logic [7:0] d, input bit last, output longint acc);
        bit got;
        got = 0;
        acc = 0;
        s_valid = 1'b1; s_data = d; s_last = last;
        for (int g = 0; g < 300 && !got; g++) begin
            @(negedge clk);
            if (s_ready_a[inst]) begin
                got = 1;
                acc = cyc;
            end
            @(posedge clk); #1;
            if (rand_mr) m_ready = 1'($urandom_range(0, 1));
        end
        if (!got) chk("send_timeout", 64'd0, 64'd1);
        s_valid = 1'b0;
    endtask

    task automatic frame(input int inst, input int nbeats, input int last_at,
                         input logic [7:0] base, output longint acc_last);
        longint a;
        acc_last = 0;
        for (int k = 0; k < nbeats; k++) begin
            send(inst, base + 8'(k), k == last_at, a);
            if (k == last_at) acc_last = a;
        end
    endtask

    task automatic wait_mv(input int inst, input longint t, input int want_lat);
        bit seen;
        seen = 0;
        for (int g = 0; g < 50 && !seen; g++) begin
            @(negedge clk);
            if (m_valid_a[inst]) seen = 1;
            else begin
                @(posedge clk); #1;
            end
        end
        if (!seen) chk("m_valid_timeout", 64'd0, 64'd1);
        else chk("latency", 64'(cyc - t), 64'(want_lat));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        longint t;
        int e0, v0, v1, len, lst;
        rst_n = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_s_ready", 64'(s_ready_a[0]), 64'd1);
        chk("rst_m_valid", 64'(m_valid_a[0]), 64'd0);
        chk("rst_core_in", 64'(core_in_a[0]), 64'd0);
        chk("rst_err", 64'(err_a[0]), 64'd0);
        @(posedge clk); #1;

        // Normal frame followed by 10 cycles of backpressure.
        m_ready = 1'b0;
        frame(0, 8, 7, 8'h01, t);
        wait_mv(0, t, 5);
        chk("normal_core_in", 64'(core_in_a[0]), 64'h0807060504030201);
        chk("normal_m_data", 64'(m_data_a[0]), 64'(alu(60'h807060504030201)));
        @(posedge clk); #1;
        for (int j = 0; j < 9; j++) begin
            @(negedge clk);
            chk("bp_m_valid", 64'(m_valid_a[0]), 64'd1);
            chk("bp_s_ready", 64'(s_ready_a[0]), 64'd0);
            @(posedge clk); #1;
        end
        m_ready = 1'b1;
        @(negedge clk);
        chk("bp_hs_m_valid", 64'(m_valid_a[0]), 64'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("bp_after_s_ready", 64'(s_ready_a[0]), 64'd1);
        chk("bp_after_m_valid", 64'(m_valid_a[0]), 64'd0);
        @(posedge clk); #1;

        // Short frame, then a full frame.
        e0 = errcnt[0]; v0 = mvcnt[0];
        frame(0, 4, 3, 8'h10, t);
        idle(10);
        chk("short_err_pulses", 64'(errcnt[0] - e0), 64'd1);
        chk("short_no_m_valid", 64'(mvcnt[0] - v0), 64'd0);
        frame(0, 8, 7, 8'h20, t);
        wait_mv(0, t, 5);
        chk("after_short_core_in", 64'(core_in_a[0]), 64'h0726252423222120);
        @(posedge clk); #1;
        idle(3);

        // Long frame: 11 beats, last on beat 10.
        e0 = errcnt[0]; v0 = mvcnt[0];
        frame(0, 11, 10, 8'h40, t);
        idle(10);
        chk("long_err_pulses", 64'(errcnt[0] - e0), 64'd1);
        chk("long_no_m_valid", 64'(mvcnt[0] - v0), 64'd0);
        chk("long_core_in", 64'(core_in_a[0]), 64'h0746454443424140);
        chk("long_s_ready", 64'(s_ready_a[0]), 64'd1);

        // Reset while the settle counter holds 2.
        v0 = mvcnt[0];
        frame(0, 8, 7, 8'h50, t);
        idle(2);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_core_in", 64'(core_in_a[0]), 64'd0);
        chk("midrst_s_ready", 64'(s_ready_a[0]), 64'd1);
        chk("midrst_m_valid", 64'(m_valid_a[0]), 64'd0);
        @(posedge clk); #1;
        idle(10);
        chk("midrst_no_m_valid", 64'(mvcnt[0] - v0), 64'd0);

        // Throughput on the fast instance: three back-to-back frames.
        m_ready = 1'b1;
        v1 = mvcnt[1];
        for (int f = 0; f < 3; f++) frame(1, 8, 7, 8'h60 + 8'(16 * f), t);
        idle(10);
        chk("thru_results", 64'(mvcnt[1] - v1), 64'd3);

        // Randomized frames, lengths, backpressure and resets.
        rand_mr = 1;
        for (int r = 0; r < 300; r++) begin
            len = $urandom_range(1, 11);
            lst = ($urandom_range(0, 5) == 0) ? len : len - 1;
            for (int k = 0; k < len; k++) begin
                send($urandom_range(0, 1), 8'($urandom), k == lst, t);
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
            end
            if ($urandom_range(0, 39) == 0) begin
                rst_n = 1'b0;
                @(posedge clk); #1;
                rst_n = 1'b1;
            end
            idle($urandom_range(0, 3));
        end
        rand_mr = 0;
        m_ready = 1'b1;
        idle(20);

        $display("== %0d vectors applied, %0d miscompares ==", nchk, nfail);
        $finish;
    end

endmodule
